// File: rtl/sprite_cmd_dispatch.sv
// Bus-fed sprite command FIFO, drained to the sprite blocks during vertical blanking,
// with front/back buffer flip on swap commands. Optional drop counter: SPRITE_CMD_DROP_COUNT_EN.
module sprite_cmd_dispatch #(
  parameter int DEPTH    = 64,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [31:0] cmd_out,
  output logic        cmd_valid
);
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [8:0] LVL_FULL = 9'(DEPTH);
  localparam logic [9:0] VBLANK   = 10'(V_ACTIVE);

  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_FLIP   = 2'd2;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [8:0]    level;
  logic [1:0]    state;
  logic          front, swap_pending;
  logic [15:0]   drop_cnt;
  logic [31:0]   head;
  logic          push, flush, full, empty, push_ok, pop, in_vblank, swap_next;
  logic          unused_ok;

  assign push      = chipselect & write & (address == 2'd0);
  assign flush     = chipselect & write & (address == 2'd3);
  assign full      = (level == LVL_FULL);
  assign empty     = (level == 9'd0);
  assign push_ok   = push & ~full & ~flush;
  assign pop       = (state == ST_DRAIN) & ~empty;
  assign in_vblank = (vcount >= VBLANK);
  assign head      = mem[rptr];
  // A swap popped on the last vblank cycle must still trigger this vblank's flip.
  assign swap_next = swap_pending | (pop & (head[20:17] == 4'hF));
  assign unused_ok = ^{hcount, head[13]};

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_ACTIVE;
      wptr         <= '0;
      rptr         <= '0;
      level        <= '0;
      front        <= 1'b0;
      swap_pending <= 1'b0;
      cmd_out      <= 32'h0;
      cmd_valid    <= 1'b0;
    end else begin
      // Dispatched words always target the back buffer.
      cmd_out   <= pop ? {head[31:14], ~front, head[12:0]} : 32'h0;
      cmd_valid <= pop;

      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        level <= '0;
      end else begin
        if (push_ok) wptr <= wptr + 1'b1;
        if (pop)     rptr <= rptr + 1'b1;
        level <= level + 9'(push_ok) - 9'(pop);
      end

      case (state)
        ST_ACTIVE: if (in_vblank) state <= ST_DRAIN;
        ST_DRAIN: begin
          swap_pending <= swap_next;
          if (!in_vblank) state <= swap_next ? ST_FLIP : ST_ACTIVE;
        end
        ST_FLIP: begin
          front        <= ~front;
          swap_pending <= 1'b0;
          state        <= ST_ACTIVE;
        end
        default: state <= ST_ACTIVE;
      endcase
    end
  end

`ifdef SPRITE_CMD_DROP_COUNT_EN
  logic drop;
  assign drop = push & full;

  always_ff @(posedge clk) begin
    if (reset || flush)
      drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end
`else
  assign drop_cnt = 16'h0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= 32'h0;
    end else if (chipselect && read) begin
      case (address)
        2'd1:    readdata <= {16'b0, level, 4'b0, front, full, empty};
        2'd2:    readdata <= {16'b0, drop_cnt};
        default: readdata <= 32'h0;
      endcase
    end else begin
      readdata <= 32'h0;
    end
  end
endmodule
